// File: rtl/fifo_push_arb.sv
// fifo_push_arb
// Round-robin arbiter that lets NUM_REQ requesters share one FIFO push port.
// The grant is combinational from the request vector, the FSM state and the
// registered round-robin pointer. The block holds no data: a beat moves
// straight from the granted requester to the FIFO when fifo_push_o is high.
//
// Optional feature: define FIFO_PUSH_ARB_BURST_LOCK_EN to enable burst
// locking. A beat with req_last_i low then keeps the grant on that requester
// until its last beat is accepted. Without the macro every accepted beat
// moves the round-robin pointer and req_last_i is ignored.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   flush_i       synchronous return to the reset state
//   req_valid_i   per-requester valid            [NUM_REQ]
//   req_data_i    word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i    per-requester last beat of a burst
//   req_ready_o   per-requester ready, at most one bit set
//   fifo_full_i   downstream FIFO full
//   fifo_push_o   push strobe to the FIFO
//   fifo_data_o   data of the granted requester (0 with no grant)
//   gnt_idx_o     index of the current grant (0 with no grant)
//   gnt_valid_o   a grant exists this cycle
//
// Handshake: a beat transfers on a cycle where the requester's valid and
// ready are both high. Ready never depends on the requester's own data, and
// a requester keeps valid, data and last stable until it sees ready.

module fifo_push_arb #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [IDX_W-1:0]              gnt_idx_o,
  output logic                          gnt_valid_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_next;

`ifndef FIFO_PUSH_ARB_BURST_LOCK_EN
  // Last flags carry no meaning when bursts are not locked.
  logic unused_last;
  assign unused_last = ^req_last_i;
`endif

  // Grant selection. LOCKED only ever considers the locked requester, so the
  // others see ready = 0 even while that requester is idle.
  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (state_q == LOCKED) begin
      if (req_valid_i[lock_idx_q]) begin
        gnt_valid = 1'b1;
        gnt_idx   = lock_idx_q;
      end
    end else begin
      // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(rr_ptr_q) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!gnt_valid && req_valid_i[IDX_W'(cand)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'(cand);
        end
      end
    end
  end

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[gnt_idx] = gnt_valid & ~fifo_full_i;
  end

  assign fifo_push_o = req_valid_i[gnt_idx] & req_ready_o[gnt_idx];
  assign fifo_data_o = gnt_valid ? req_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH]
                                 : '0;
  assign gnt_idx_o   = gnt_idx;
  assign gnt_valid_o = gnt_valid;

  // Pointer moves one past the requester whose arbitration just ended.
  assign rr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      // Flush beats a simultaneous accepted beat.
      state_d    = IDLE;
      rr_ptr_d   = '0;
      lock_idx_d = '0;
    end else if (fifo_push_o) begin
`ifdef FIFO_PUSH_ARB_BURST_LOCK_EN
      if (state_q == IDLE) begin
        if (!req_last_i[gnt_idx]) begin
          // Burst start: pointer holds until the burst finishes.
          state_d    = LOCKED;
          lock_idx_d = gnt_idx;
        end else begin
          rr_ptr_d = rr_next;
        end
      end else if (req_last_i[lock_idx_q]) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next;
      end
`else
      rr_ptr_d = rr_next;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb with NUM_REQ=4, DATA_WIDTH=32.
module tb_fifo_push_arb;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]    req_last_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic             fifo_full_i = 1'b0;
  logic             fifo_push_o;
  logic [DW-1:0]    fifo_data_o;
  logic [1:0]       gnt_idx_o;
  logic             gnt_valid_o;

  fifo_push_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .fifo_full_i (fifo_full_i),
    .fifo_push_o (fifo_push_o),
    .fifo_data_o (fifo_data_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] words[NR];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic          full;
    logic          fl;
    logic          gv;
    logic [1:0]    idx;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                              input logic full, input logic gv,
                              input logic [1:0] idx);
    vec_t r;
    r.v = v; r.l = l; r.full = full; r.fl = 1'b0; r.gv = gv; r.idx = idx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs at negedge, check combinational outputs 1 time unit
  // later, then let the rising edge commit the cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] l,
                      input logic full, input logic fl, input logic gv,
                      input logic [1:0] idx, input string name);
    logic [NR-1:0] exp_rdy;
    logic          exp_push;
    logic [DW-1:0] d;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
      words[i] = $urandom_range(32'hFFFF_FFFF, 0);
      req_data_i[i*DW +: DW] = words[i];
    end
    req_valid_i = v;
    req_last_i  = l;
    fifo_full_i = full;
    flush_i     = fl;
    exp_push = gv && !full;
    exp_rdy  = exp_push ? (4'b0001 << idx) : 4'b0000;
    if (exp_push) exp_q.push_back(words[idx]);
    #1;
    chk({name, ".gnt_valid"}, DW'(gnt_valid_o), DW'(gv));
    chk({name, ".gnt_idx"},   DW'(gnt_idx_o),   DW'(gv ? idx : 2'd0));
    chk({name, ".ready"},     DW'(req_ready_o), DW'(exp_rdy));
    chk({name, ".push"},      DW'(fifo_push_o), DW'(exp_push));
    if (fifo_push_o) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL %s.data: got push of %h, want no push", name, fifo_data_o);
      end else begin
        d = exp_q.pop_front();
        chk({name, ".data"}, fifo_data_o, d);
      end
    end else begin
      chk({name, ".data_idle"}, fifo_data_o, gv ? words[idx] : '0);
    end
    @(posedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    req_valid_i = '0; req_last_i = '0; fifo_full_i = 1'b0; flush_i = 1'b0;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset, first handshakes, wrap, full stall
    tbl[0]  = mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0); // outputs all 0
    tbl[1]  = mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0);
    tbl[2]  = mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd1);
    tbl[3]  = mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd2);
    tbl[4]  = mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd3);
    tbl[5]  = mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0); // rr=1 after
    tbl[6]  = mk(4'b0010, 4'b1111, 1'b0, 1'b1, 2'd1); // rr=2
    tbl[7]  = mk(4'b0100, 4'b1111, 1'b0, 1'b1, 2'd2); // rr=3
    tbl[8]  = mk(4'b1001, 4'b1111, 1'b0, 1'b1, 2'd3); // wrap -> rr=0
    tbl[9]  = mk(4'b1001, 4'b1111, 1'b0, 1'b1, 2'd0); // rr=1
    tbl[10] = mk(4'b0110, 4'b1111, 1'b1, 1'b1, 2'd1); // full stall x3
    tbl[11] = mk(4'b0110, 4'b1111, 1'b1, 1'b1, 2'd1);
    tbl[12] = mk(4'b0110, 4'b1111, 1'b1, 1'b1, 2'd1);
    tbl[13] = mk(4'b0110, 4'b1111, 1'b0, 1'b1, 2'd1); // accepted, rr=2
    tbl[14] = mk(4'b0110, 4'b1111, 1'b0, 1'b1, 2'd2); // rr=3
    tbl[15] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int k = 0; k < 16; k++)
      step(tbl[k].v, tbl[k].l, tbl[k].full, tbl[k].fl, tbl[k].gv,
           tbl[k].idx, $sformatf("tbl%0d", k));

    // Burst from requester 2 while requester 0 stays valid
    do_reset();
    step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, "lk_pre");   // rr=1
`ifdef FIFO_PUSH_ARB_BURST_LOCK_EN
    step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, "lk_b0");    // lock 2
    step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "lk_hold");  // 0 blocked
    step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, "lk_b1");
    step(4'b0101, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, "lk_b2");    // rr=3
    step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "lk_then0");
`else
    step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, "lk_b0");    // rr=3
    step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "lk_r0");    // rr=1
    step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, "lk_b1");    // rr=3
    step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "lk_then0");
`endif

    // Flush mid-burst on requester 1
    do_reset();
    step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, "fl_pre");   // rr=1
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, "fl_lock");
`ifdef FIFO_PUSH_ARB_BURST_LOCK_EN
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, "fl_flush");
`else
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, "fl_flush");
`endif
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "fl_after");

    // Asynchronous reset pulse mid-burst on requester 1
    do_reset();
    step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, "rs_pre");   // rr=1
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, "rs_lock");
    #2;
    rst_i = 1'b1;
    #1;
    chk("rs_during.gnt_idx", DW'(gnt_idx_o), DW'(2'd0));
    rst_i = 1'b0;
    void'(exp_q.size());
    // The in-reset check may have seen a combinational push; drop its data.
    exp_q.delete();
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "rs_after");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "rs_idle");

    chk("sb_empty", DW'(exp_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FIFO push port (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-003 SHALL derive the local IDX_W as max(1, clog2(NUM_REQ)); IDX_W SHALL NOT be overridable.
REQ-004 One clock; reset is asynchronous and active-high: clk_i, input, 1, rising-edge clock.
REQ-005 rst_i, input, 1, asynchronous active-high reset.
REQ-006 flush_i, input, 1, synchronous return to reset state.
REQ-007 req_valid_i, input, NUM_REQ, per-requester valid.
REQ-008 req_data_i, input, NUM_REQ*DATA_WIDTH, word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last_i, input, NUM_REQ, final beat of a burst.
REQ-010 req_ready_o, output, NUM_REQ, per-requester ready; at most one bit set.
REQ-011 fifo_full_i, input, 1, full flag of the downstream FIFO.
REQ-012 fifo_push_o, output, 1, push strobe to the FIFO.
REQ-013 fifo_data_o, output, DATA_WIDTH, data of the granted requester.
REQ-014 gnt_idx_o, output, IDX_W, index of the current grant; gnt_valid_o, output, 1, grant exists.

Function
REQ-015 Grant selection SHALL be combinational (zero latency) from req_valid_i, the registered state and the registered round-robin pointer rr_ptr.
REQ-016 In state IDLE, the grant SHALL go to the first valid requester at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
REQ-017 gnt_valid_o SHALL be 1 when any eligible requester is valid; gnt_idx_o SHALL be 0 when gnt_valid_o is 0.
REQ-018 req_ready_o[g] SHALL equal gnt_valid_o AND NOT fifo_full_i, where g = gnt_idx_o; all other ready bits SHALL be 0.
REQ-019 fifo_push_o SHALL equal req_valid_i[g] AND req_ready_o[g]; fifo_data_o SHALL carry word g, and SHALL be 0 when gnt_valid_o is 0.
REQ-020 A beat SHALL be accepted only on a cycle with fifo_push_o = 1.
REQ-021 When fifo_full_i = 1, no beat SHALL be accepted, and rr_ptr and the state SHALL hold.
REQ-022 On an accepted beat from g that ends arbitration (see REQ-024/REQ-030), rr_ptr SHALL become (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-023 Cycles with no accepted beat SHALL leave rr_ptr unchanged.
REQ-024 The state machine SHALL have two states, IDLE and LOCKED, with register lock_idx (IDX_W).
- IDLE -> LOCKED: on an accepted beat with req_last_i[g] = 0; lock_idx <= g.
- LOCKED -> IDLE: on an accepted beat with req_last_i[lock_idx] = 1; rr_ptr updates per REQ-022.
REQ-025 In LOCKED, only lock_idx SHALL be eligible; other requesters SHALL see ready = 0 even when lock_idx is not valid.
REQ-026 When flush_i and an accepted beat occur in the same cycle, flush_i SHALL win and the beat SHALL NOT update state.
REQ-027 Each requester SHALL hold valid, data and last stable until it sees ready; the block SHALL NOT buffer data.

Reset
REQ-028 While rst_i = 1 (asynchronously), and on a cycle with flush_i = 1, the block SHALL return to state IDLE with rr_ptr = 0 and lock_idx = 0.
REQ-029 Reset mid-burst SHALL abandon the lock; the first cycle after reset SHALL grant from index 0 upward. Outputs SHALL follow REQ-017..REQ-019 from this state: with no valid inputs, all outputs are 0.

Configuration
REQ-030 Macro FIFO_PUSH_ARB_BURST_LOCK_EN controls burst locking.
- Defined: the IDLE/LOCKED behaviour of REQ-024/REQ-025 SHALL apply.
- Undefined: the state SHALL remain IDLE, req_last_i SHALL be ignored, and every accepted beat SHALL update rr_ptr.

Verification
REQ-031 Reset: after rst_i is released with no valid inputs, all outputs SHALL be 0. Then req_valid_i=4'b1111, full=0 -> grant order 0,1,2,3,0 on consecutive cycles (all last=1).
REQ-032 Wrap: rr_ptr=3 with req_valid_i=4'b1001 -> grant 3, then 0; rr_ptr returns to 0 after grant 3.
REQ-033 Full stall: fifo_full_i=1 for 3 cycles with req_valid_i=4'b0110 -> ready=0, push=0, gnt_idx_o=1 held; full drops -> requester 1 accepted.
REQ-034 Lock (macro defined): requester 2 sends 3 beats with last=0,0,1 while requester 0 stays valid -> pushes 2,2,2, then 0. Macro undefined -> pushes 2,0,2.
REQ-035 Flush/reset mid-burst: assert flush_i in LOCKED on lock_idx=1 with req_valid_i=4'b0011 -> next grant 0. Repeat with rst_i pulsed asynchronously -> same result.
